// File: rtl/pipeline_hazard_ctrl_if.sv
// Handshake bundle between the 5-stage pipeline datapath and its hazard controller.
// master: pipeline side (drives hazard sources, receives stage controls).
// slave:  controller side.
interface pipeline_hazard_ctrl_if #(
  parameter int REGIDX = 5
);
  logic [REGIDX-1:0] id_rs1;
  logic [REGIDX-1:0] id_rs2;
  logic              id_use1;
  logic              id_use2;
  logic [REGIDX-1:0] ex_rs1;
  logic [REGIDX-1:0] ex_rs2;
  logic [REGIDX-1:0] ex_rd;
  logic              ex_memread;
  logic              ex_br_taken;
  logic [REGIDX-1:0] mem_rd;
  logic              mem_we;
  logic [REGIDX-1:0] wb_rd;
  logic              wb_we;
  logic              dmem_req;
  logic              dmem_ready;

  logic              pc_en;
  logic              ifid_en;
  logic              idex_en;
  logic              exmem_en;
  logic              memwb_en;
  logic              ifid_flush;
  logic              idex_flush;
  logic              memwb_flush;
  logic [1:0]        fwd_a;
  logic [1:0]        fwd_b;
  logic              mem_timeout;

  modport master (
    output id_rs1, id_rs2, id_use1, id_use2, ex_rs1, ex_rs2, ex_rd, ex_memread,
           ex_br_taken, mem_rd, mem_we, wb_rd, wb_we, dmem_req, dmem_ready,
    input  pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush,
           memwb_flush, fwd_a, fwd_b, mem_timeout
  );

  modport slave (
    input  id_rs1, id_rs2, id_use1, id_use2, ex_rs1, ex_rs2, ex_rd, ex_memread,
           ex_br_taken, mem_rd, mem_we, wb_rd, wb_we, dmem_req, dmem_ready,
    output pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush,
           memwb_flush, fwd_a, fwd_b, mem_timeout
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard sequencer for a 5-stage RV32 pipeline: stage enables/flushes, EX operand
// forwarding, load-use stalls, taken-branch flushes and data-memory wait with watchdog.
// Optional macro HAZ_PERF_CNT_EN adds stall_cnt/flush_cnt performance counters.
//
// state | meaning
// RUN   | normal flow; branch/load-use hazards handled in-cycle
// MWAIT | data memory busy; pipeline frozen, wait_cnt counts frozen cycles
// ERR   | memory watchdog expired; pipeline halted until rst
//
// The bus interface REGIDX parameter must equal this module's REGIDX.
module pipeline_hazard_ctrl #(
  parameter int REGIDX  = 5,
  parameter int TIMEOUT = 255,
  parameter int CNTW    = 8
) (
  input  logic                     clk,
  input  logic                     rst,
`ifdef HAZ_PERF_CNT_EN
  output logic [31:0]              stall_cnt,
  output logic [31:0]              flush_cnt,
`endif
  pipeline_hazard_ctrl_if.slave    bus
);

  typedef enum logic [1:0] {RUN = 2'd0, MWAIT = 2'd1, ERR = 2'd2} state_t;

  localparam logic [REGIDX-1:0] X0        = '0;
  localparam logic [CNTW-1:0]   TIMEOUT_C = CNTW'(TIMEOUT);

  state_t          state, state_nxt;
  logic [CNTW-1:0] wait_cnt, cnt_nxt;

  logic pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic ifid_flush, idex_flush, memwb_flush;
  logic mem_timeout, br_flush, eval_hz, load_use, mem_stall;
  logic [1:0] fwd_a, fwd_b;

  assign load_use = bus.ex_memread && (bus.ex_rd != X0) &&
                    ((bus.id_use1 && (bus.id_rs1 == bus.ex_rd)) ||
                     (bus.id_use2 && (bus.id_rs2 == bus.ex_rd)));
  assign mem_stall = bus.dmem_req && !bus.dmem_ready;

  // State and wait counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RUN;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= cnt_nxt;
    end
  end

  // Next-state and stage control decode; mem-wait beats branch beats load-use.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = wait_cnt;
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    idex_en     = 1'b1;
    exmem_en    = 1'b1;
    memwb_en    = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    memwb_flush = 1'b0;
    mem_timeout = 1'b0;
    br_flush    = 1'b0;
    eval_hz     = 1'b0;

    case (state)
      RUN: begin
        if (mem_stall) begin
          state_nxt = MWAIT;
          cnt_nxt   = CNTW'(1);
        end else begin
          eval_hz = 1'b1;
        end
      end
      MWAIT: begin
        if (bus.dmem_ready) begin
          state_nxt = RUN;
          cnt_nxt   = '0;
          eval_hz   = 1'b1;
        end else if (wait_cnt >= TIMEOUT_C) begin
          state_nxt = ERR;
        end else begin
          // Never exceeds TIMEOUT_C, so the counter cannot wrap.
          cnt_nxt = wait_cnt + CNTW'(1);
        end
      end
      ERR: begin
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        idex_en     = 1'b0;
        exmem_en    = 1'b0;
        memwb_en    = 1'b0;
        mem_timeout = 1'b1;
      end
      default: state_nxt = RUN;
    endcase

    // Freeze everything up to MEM and drop a bubble into MEM/WB while memory is busy.
    if ((state == RUN || state == MWAIT) && !eval_hz) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_en    = 1'b0;
      memwb_flush = 1'b1;
    end

    if (eval_hz) begin
      if (bus.ex_br_taken) begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
        br_flush   = 1'b1;
      end else if (load_use) begin
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        idex_flush = 1'b1;
      end
    end

    if (rst) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_en    = 1'b0;
      memwb_en    = 1'b0;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      memwb_flush = 1'b1;
      mem_timeout = 1'b0;
      br_flush    = 1'b0;
    end
  end

  // EX operand forwarding; EX/MEM is newer than MEM/WB so it wins, x0 is never forwarded.
  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (!rst) begin
      if (bus.mem_we && bus.mem_rd != X0 && bus.mem_rd == bus.ex_rs1)
        fwd_a = 2'b10;
      else if (bus.wb_we && bus.wb_rd != X0 && bus.wb_rd == bus.ex_rs1)
        fwd_a = 2'b01;
      if (bus.mem_we && bus.mem_rd != X0 && bus.mem_rd == bus.ex_rs2)
        fwd_b = 2'b10;
      else if (bus.wb_we && bus.wb_rd != X0 && bus.wb_rd == bus.ex_rs2)
        fwd_b = 2'b01;
    end
  end

`ifdef HAZ_PERF_CNT_EN
  // Performance counters: stalled-PC cycles while active, and taken-branch flush cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!pc_en && state != ERR) stall_cnt <= stall_cnt + 32'd1;
      if (br_flush)               flush_cnt <= flush_cnt + 32'd1;
    end
  end
`else
  logic unused_br_flush;
  assign unused_br_flush = br_flush;
`endif

  assign bus.pc_en       = pc_en;
  assign bus.ifid_en     = ifid_en;
  assign bus.idex_en     = idex_en;
  assign bus.exmem_en    = exmem_en;
  assign bus.memwb_en    = memwb_en;
  assign bus.ifid_flush  = ifid_flush;
  assign bus.idex_flush  = idex_flush;
  assign bus.memwb_flush = memwb_flush;
  assign bus.fwd_a       = fwd_a;
  assign bus.fwd_b       = fwd_b;
  assign bus.mem_timeout = mem_timeout;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl with TIMEOUT=8.
module tb_pipeline_hazard_ctrl;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  pipeline_hazard_ctrl_if #(.REGIDX(5)) bus ();

`ifdef HAZ_PERF_CNT_EN
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;
`endif

  pipeline_hazard_ctrl #(.REGIDX(5), .TIMEOUT(8), .CNTW(8)) dut (
    .clk       (clk),
    .rst       (rst),
`ifdef HAZ_PERF_CNT_EN
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt),
`endif
    .bus       (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // {pc,ifid,idex,exmem,memwb enables, ifid,idex,memwb flushes}
  localparam logic [7:0] C_RST = 8'b00000_111;
  localparam logic [7:0] C_RUN = 8'b11111_000;
  localparam logic [7:0] C_LU  = 8'b00111_010;
  localparam logic [7:0] C_BR  = 8'b11111_110;
  localparam logic [7:0] C_FRZ = 8'b00001_001;
  localparam logic [7:0] C_ERR = 8'b00000_000;

  // Compares controls/forwarding/timeout at the falling edge, then advances one cycle.
  task automatic chk(input string tag, input logic [7:0] ctl, input logic [1:0] fa,
                     input logic [1:0] fb, input logic to);
    logic [12:0] obs, exp_v;
    @(negedge clk);
    obs = {bus.pc_en, bus.ifid_en, bus.idex_en, bus.exmem_en, bus.memwb_en,
           bus.ifid_flush, bus.idex_flush, bus.memwb_flush, bus.fwd_a, bus.fwd_b,
           bus.mem_timeout};
    exp_v = {ctl, fa, fb, to};
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp_v);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.id_rs1 = '0; bus.id_rs2 = '0; bus.id_use1 = 1'b0; bus.id_use2 = 1'b0;
    bus.ex_rs1 = '0; bus.ex_rs2 = '0; bus.ex_rd = '0; bus.ex_memread = 1'b0;
    bus.ex_br_taken = 1'b0; bus.mem_rd = '0; bus.mem_we = 1'b0;
    bus.wb_rd = '0; bus.wb_we = 1'b0; bus.dmem_req = 1'b0; bus.dmem_ready = 1'b0;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    clear_inputs();

    // reset held three cycles
    chk("rst_c1", C_RST, 2'b00, 2'b00, 1'b0);
    chk("rst_c2", C_RST, 2'b00, 2'b00, 1'b0);
    chk("rst_c3", C_RST, 2'b00, 2'b00, 1'b0);
    rst = 1'b0;
    chk("run_after_rst", C_RUN, 2'b00, 2'b00, 1'b0);

    // load-use on rs1, single bubble
    bus.ex_memread = 1'b1; bus.ex_rd = 5'd5; bus.id_use1 = 1'b1; bus.id_rs1 = 5'd5;
    chk("loaduse_rs1", C_LU, 2'b00, 2'b00, 1'b0);
    bus.ex_memread = 1'b0;
    chk("loaduse_done", C_RUN, 2'b00, 2'b00, 1'b0);

    // load-use on rs2
    bus.ex_memread = 1'b1; bus.id_use1 = 1'b0; bus.id_use2 = 1'b1; bus.id_rs2 = 5'd5;
    chk("loaduse_rs2", C_LU, 2'b00, 2'b00, 1'b0);
    // rs2 matches but is not read
    bus.id_use2 = 1'b0;
    chk("loaduse_unused", C_RUN, 2'b00, 2'b00, 1'b0);
    // load to x0 never stalls
    bus.id_use1 = 1'b1; bus.id_rs1 = 5'd0; bus.ex_rd = 5'd0;
    chk("loaduse_x0", C_RUN, 2'b00, 2'b00, 1'b0);

    // branch with concurrent load-use: flush wins
    bus.ex_rd = 5'd5; bus.id_rs1 = 5'd5; bus.ex_br_taken = 1'b1;
    chk("branch_over_lu", C_BR, 2'b00, 2'b00, 1'b0);
    clear_inputs();
    chk("branch_done", C_RUN, 2'b00, 2'b00, 1'b0);

    // single-cycle memory access does not stall
    bus.dmem_req = 1'b1; bus.dmem_ready = 1'b1;
    chk("mem_1cyc", C_RUN, 2'b00, 2'b00, 1'b0);

    // four busy cycles then release on the fifth; branch present but outranked
    bus.dmem_ready = 1'b0; bus.ex_br_taken = 1'b1;
    chk("mwait_1", C_FRZ, 2'b00, 2'b00, 1'b0);
    bus.ex_br_taken = 1'b0;
    chk("mwait_2", C_FRZ, 2'b00, 2'b00, 1'b0);
    chk("mwait_3", C_FRZ, 2'b00, 2'b00, 1'b0);
    chk("mwait_4", C_FRZ, 2'b00, 2'b00, 1'b0);
    bus.dmem_ready = 1'b1;
    chk("mwait_release", C_RUN, 2'b00, 2'b00, 1'b0);
    bus.dmem_req = 1'b0; bus.dmem_ready = 1'b0;
    chk("mwait_back_run", C_RUN, 2'b00, 2'b00, 1'b0);

    // release cycle still evaluates load-use
    bus.dmem_req = 1'b1;
    chk("mwait2_entry", C_FRZ, 2'b00, 2'b00, 1'b0);
    bus.dmem_ready = 1'b1; bus.ex_memread = 1'b1; bus.ex_rd = 5'd9;
    bus.id_use2 = 1'b1; bus.id_rs2 = 5'd9;
    chk("release_loaduse", C_LU, 2'b00, 2'b00, 1'b0);
    clear_inputs();

    // forwarding
    bus.mem_rd = 5'd3; bus.wb_rd = 5'd3; bus.ex_rs1 = 5'd3;
    bus.mem_we = 1'b1; bus.wb_we = 1'b1;
    chk("fwd_a_exmem", C_RUN, 2'b10, 2'b00, 1'b0);
    bus.mem_we = 1'b0;
    chk("fwd_a_memwb", C_RUN, 2'b01, 2'b00, 1'b0);
    bus.ex_rs1 = 5'd0; bus.mem_rd = 5'd0; bus.wb_rd = 5'd0; bus.mem_we = 1'b1;
    chk("fwd_a_x0", C_RUN, 2'b00, 2'b00, 1'b0);
    bus.ex_rs2 = 5'd7; bus.wb_rd = 5'd7; bus.mem_rd = 5'd4; bus.ex_rs1 = 5'd4;
    chk("fwd_mixed", C_RUN, 2'b10, 2'b01, 1'b0);
    bus.mem_rd = 5'd7;
    chk("fwd_b_exmem", C_RUN, 2'b00, 2'b10, 1'b0);
    clear_inputs();

    // watchdog: entry cycle plus 8 MWAIT cycles, then ERR
    bus.dmem_req = 1'b1;
    chk("to_entry", C_FRZ, 2'b00, 2'b00, 1'b0);
    for (int i = 1; i <= 8; i++) chk($sformatf("to_wait_%0d", i), C_FRZ, 2'b00, 2'b00, 1'b0);
    chk("err_enter", C_ERR, 2'b00, 2'b00, 1'b1);
    bus.dmem_ready = 1'b1;
    chk("err_sticky_ready", C_ERR, 2'b00, 2'b00, 1'b1);
    bus.dmem_req = 1'b0; bus.ex_br_taken = 1'b1;
    chk("err_sticky_br", C_ERR, 2'b00, 2'b00, 1'b1);
    clear_inputs();
    rst = 1'b1;
    chk("err_rst", C_RST, 2'b00, 2'b00, 1'b0);
    rst = 1'b0;
    chk("err_cleared", C_RUN, 2'b00, 2'b00, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
